// File: rtl/pulse_sweep_pkg.sv
// Shared types for the pulse sweep sequencer: FSM states, loop-order codes
// and the mapping from loop_order to the inner/mid/outer sweep dimensions.
package pulse_sweep_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, VERIFY, DONE} state_t;

  localparam logic [1:0] DIM_A  = 2'd0;
  localparam logic [1:0] DIM_B  = 2'd1;
  localparam logic [1:0] DIM_PW = 2'd2;

  localparam logic [2:0] ORD_PW_B_A = 3'd0;
  localparam logic [2:0] ORD_PW_A_B = 3'd1;
  localparam logic [2:0] ORD_B_PW_A = 3'd2;
  localparam logic [2:0] ORD_B_A_PW = 3'd3;
  localparam logic [2:0] ORD_A_PW_B = 3'd4;
  localparam logic [2:0] ORD_A_B_PW = 3'd5;

  typedef struct packed {
    logic [1:0] inner;
    logic [1:0] mid;
    logic [1:0] outer;
  } dim_order_t;

  // Codes 6 and 7 are unused and fall back to the default pw,b,a nesting
  function automatic dim_order_t order_map(input logic [2:0] order);
    dim_order_t m;
    case (order)
      ORD_PW_A_B: m = '{inner: DIM_PW, mid: DIM_A,  outer: DIM_B};
      ORD_B_PW_A: m = '{inner: DIM_B,  mid: DIM_PW, outer: DIM_A};
      ORD_B_A_PW: m = '{inner: DIM_B,  mid: DIM_A,  outer: DIM_PW};
      ORD_A_PW_B: m = '{inner: DIM_A,  mid: DIM_PW, outer: DIM_B};
      ORD_A_B_PW: m = '{inner: DIM_A,  mid: DIM_B,  outer: DIM_PW};
      default:    m = '{inner: DIM_PW, mid: DIM_B,  outer: DIM_A};
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sweep_dim.sv
// One sweep dimension: holds the current value, loads start, and steps
// towards stop, wrapping back to start and flagging carry when it runs out.
module sweep_dim #(
  parameter int W = 8
) (
  input  logic         mclk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         adv,
  input  logic [W-1:0] start,
  input  logic [W-1:0] stop,
  input  logic [W-1:0] step,
  output logic [W-1:0] value,
  output logic         carry
);

  logic [W:0] next;

  assign next = {1'b0, value} + {1'b0, step};

  // An empty range (start>stop) always wraps, so it holds the single value start
  assign carry = (step == '0) || next[W] || (next[W-1:0] > stop) || (start > stop);

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= start;
    end else if (adv) begin
      value <= carry ? start : next[W-1:0];
    end
  end

endmodule

// File: rtl/pulse_sweep_seq.sv
// Write-pulse sweep sequencer for RRAM write-verify: steps levels A/B and pulse width.
// Build option PULSE_SWEEP_STATS_EN adds the pulse_cycles statistics output.
module pulse_sweep_seq
  import pulse_sweep_pkg::*;
#(
  parameter int LVL_W     = 8,
  parameter int PW_W      = 8,
  parameter int ATT_W     = 8,
  parameter int SETUP_CYC = 2
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LVL_W-1:0] lvl_a_start,
  input  logic [LVL_W-1:0] lvl_a_stop,
  input  logic [LVL_W-1:0] lvl_a_step,
  input  logic [LVL_W-1:0] lvl_b_start,
  input  logic [LVL_W-1:0] lvl_b_stop,
  input  logic [LVL_W-1:0] lvl_b_step,
  input  logic [PW_W-1:0]  pw_start,
  input  logic [PW_W-1:0]  pw_stop,
  input  logic [PW_W-1:0]  pw_step,
  input  logic [2:0]       loop_order,
  input  logic [ATT_W-1:0] max_attempts,
  input  logic             vfy_done,
  input  logic             vfy_pass,
  output logic [LVL_W-1:0] lvl_a,
  output logic [LVL_W-1:0] lvl_b,
  output logic [PW_W-1:0]  cur_pw,
  output logic             pulse_en,
  output logic             vfy_req,
  output logic             busy,
  output logic             done,
  output logic             success,
  output logic             aborted,
`ifdef PULSE_SWEEP_STATS_EN
  output logic [23:0]      pulse_cycles,
`endif
  output logic [ATT_W-1:0] attempts
);

  localparam int SC_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

  state_t          state;
  dim_order_t      ord;
  logic [2:0]      carry;
  logic [2:0]      adv;
  logic            load;
  logic            active;
  logic            limit_hit;
  logic            exhausted;
  logic            step_sweep;
  logic [SC_W-1:0] setup_cnt;
  logic [PW_W-1:0] pulse_cnt;
  logic [PW_W-1:0] pw_len;

  assign load       = (state == IDLE) && start;
  assign active     = (state == SETUP) || (state == PULSE) || (state == VERIFY);
  assign limit_hit  = (max_attempts != '0) && (attempts == max_attempts);
  assign exhausted  = &carry;
  assign step_sweep = (state == VERIFY) && vfy_done && !vfy_pass && !abort
                      && !limit_hit && !exhausted;
  assign pw_len     = (cur_pw == '0) ? PW_W'(1) : cur_pw;

  // Carry chain follows the selected nesting: mid steps only when inner wraps
  always_comb begin
    ord = order_map(loop_order);
    adv = '0;
    if (step_sweep) begin
      adv[ord.inner] = 1'b1;
      adv[ord.mid]   = carry[ord.inner];
      adv[ord.outer] = carry[ord.inner] & carry[ord.mid];
    end
  end

  sweep_dim #(.W(LVL_W)) u_dim_a (
    .mclk(mclk), .rst_n(rst_n), .load(load), .adv(adv[DIM_A]),
    .start(lvl_a_start), .stop(lvl_a_stop), .step(lvl_a_step),
    .value(lvl_a), .carry(carry[DIM_A])
  );

  sweep_dim #(.W(LVL_W)) u_dim_b (
    .mclk(mclk), .rst_n(rst_n), .load(load), .adv(adv[DIM_B]),
    .start(lvl_b_start), .stop(lvl_b_stop), .step(lvl_b_step),
    .value(lvl_b), .carry(carry[DIM_B])
  );

  sweep_dim #(.W(PW_W)) u_dim_pw (
    .mclk(mclk), .rst_n(rst_n), .load(load), .adv(adv[DIM_PW]),
    .start(pw_start), .stop(pw_stop), .step(pw_step),
    .value(cur_pw), .carry(carry[DIM_PW])
  );

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      state     <= IDLE;
      pulse_en  <= 1'b0;
      vfy_req   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      success   <= 1'b0;
      aborted   <= 1'b0;
      attempts  <= '0;
      setup_cnt <= '0;
      pulse_cnt <= '0;
    end else begin
      done <= 1'b0;
      // Abort takes priority over any verify result arriving in the same cycle
      if (abort && active) begin
        state    <= DONE;
        done     <= 1'b1;
        aborted  <= 1'b1;
        success  <= 1'b0;
        pulse_en <= 1'b0;
        vfy_req  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= SETUP;
              busy      <= 1'b1;
              attempts  <= '0;
              success   <= 1'b0;
              aborted   <= 1'b0;
              setup_cnt <= '0;
            end
          end
          SETUP: begin
            if (setup_cnt == SC_W'(SETUP_CYC - 1)) begin
              state     <= PULSE;
              pulse_en  <= 1'b1;
              pulse_cnt <= '0;
              if (attempts != '1) attempts <= attempts + ATT_W'(1);
            end else begin
              setup_cnt <= setup_cnt + SC_W'(1);
            end
          end
          PULSE: begin
            if (pulse_cnt == pw_len - PW_W'(1)) begin
              state    <= VERIFY;
              pulse_en <= 1'b0;
              vfy_req  <= 1'b1;
            end else begin
              pulse_cnt <= pulse_cnt + PW_W'(1);
            end
          end
          VERIFY: begin
            if (vfy_done) begin
              vfy_req <= 1'b0;
              if (vfy_pass || limit_hit || exhausted) begin
                state   <= DONE;
                done    <= 1'b1;
                success <= vfy_pass;
              end else begin
                state     <= SETUP;
                setup_cnt <= '0;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef PULSE_SWEEP_STATS_EN
  always_ff @(posedge mclk) begin
    if (!rst_n || load) begin
      pulse_cycles <= '0;
    end else if (pulse_en && (pulse_cycles != '1)) begin
      pulse_cycles <= pulse_cycles + 24'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pulse_sweep_seq.sv
// Self-checking bench for pulse_sweep_seq: directed scenarios plus random sweeps
// compared against a nested-loop list model of the expected sweep points.
module tb_pulse_sweep_seq;

  localparam int LVL_W     = 8;
  localparam int PW_W      = 8;
  localparam int ATT_W     = 8;
  localparam int SETUP_CYC = 2;

  logic             mclk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             vfy_done = 1'b0;
  logic             vfy_pass = 1'b0;
  logic [LVL_W-1:0] lvl_a_start = '0, lvl_a_stop = '0, lvl_a_step = '0;
  logic [LVL_W-1:0] lvl_b_start = '0, lvl_b_stop = '0, lvl_b_step = '0;
  logic [PW_W-1:0]  pw_start = '0, pw_stop = '0, pw_step = '0;
  logic [2:0]       loop_order = '0;
  logic [ATT_W-1:0] max_attempts = '0;
  logic [LVL_W-1:0] lvl_a, lvl_b;
  logic [PW_W-1:0]  cur_pw;
  logic             pulse_en, vfy_req, busy, done, success, aborted;
  logic [ATT_W-1:0] attempts;
`ifdef PULSE_SWEEP_STATS_EN
  logic [23:0]      pulse_cycles;
`endif

  int vectors = 0;
  int miscompares = 0;

  // inner, mid, outer dimension per loop_order (0=a, 1=b, 2=pw)
  int ord_tab[8][3] = '{'{2,1,0}, '{2,0,1}, '{1,2,0}, '{1,0,2},
                        '{0,2,1}, '{0,1,2}, '{2,1,0}, '{2,1,0}};
  int pa[$], pb[$], pp[$];

  pulse_sweep_seq #(
    .LVL_W(LVL_W), .PW_W(PW_W), .ATT_W(ATT_W), .SETUP_CYC(SETUP_CYC)
  ) dut (
    .mclk(mclk), .rst_n(rst_n), .start(start), .abort(abort),
    .lvl_a_start(lvl_a_start), .lvl_a_stop(lvl_a_stop), .lvl_a_step(lvl_a_step),
    .lvl_b_start(lvl_b_start), .lvl_b_stop(lvl_b_stop), .lvl_b_step(lvl_b_step),
    .pw_start(pw_start), .pw_stop(pw_stop), .pw_step(pw_step),
    .loop_order(loop_order), .max_attempts(max_attempts),
    .vfy_done(vfy_done), .vfy_pass(vfy_pass),
    .lvl_a(lvl_a), .lvl_b(lvl_b), .cur_pw(cur_pw),
    .pulse_en(pulse_en), .vfy_req(vfy_req), .busy(busy), .done(done),
    .success(success), .aborted(aborted),
`ifdef PULSE_SWEEP_STATS_EN
    .pulse_cycles(pulse_cycles),
`endif
    .attempts(attempts)
  );

  always #5 mclk = ~mclk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_flags"}, {26'd0, pulse_en, vfy_req, busy, done, success, aborted}, 32'd0);
    checkOutput({tag, "_values"}, {attempts, lvl_a, lvl_b, cur_pw}, 32'd0);
  endtask

  task automatic loadConfig(input int as, input int ae, input int ast,
                            input int bs, input int be, input int bst,
                            input int ps, input int pe, input int pst,
                            input int ord, input int maxa);
    lvl_a_start = LVL_W'(as); lvl_a_stop = LVL_W'(ae); lvl_a_step = LVL_W'(ast);
    lvl_b_start = LVL_W'(bs); lvl_b_stop = LVL_W'(be); lvl_b_step = LVL_W'(bst);
    pw_start = PW_W'(ps); pw_stop = PW_W'(pe); pw_step = PW_W'(pst);
    loop_order = 3'(ord);
    max_attempts = ATT_W'(maxa);
  endtask

  // Each dimension is the list start, start+step, ... up to stop; points are its nested product
  task automatic buildModel();
    int vals[3][256];
    int len[3];
    int s[3], e[3], st[3], pt[3];
    int di, dm, dout;
    s  = '{int'(lvl_a_start), int'(lvl_b_start), int'(pw_start)};
    e  = '{int'(lvl_a_stop),  int'(lvl_b_stop),  int'(pw_stop)};
    st = '{int'(lvl_a_step),  int'(lvl_b_step),  int'(pw_step)};
    for (int d = 0; d < 3; d++) begin
      len[d] = 0;
      if (s[d] > e[d] || st[d] == 0) begin
        vals[d][0] = s[d];
        len[d] = 1;
      end else begin
        for (int v = s[d]; v <= e[d]; v += st[d]) begin
          vals[d][len[d]] = v;
          len[d]++;
        end
      end
    end
    di = ord_tab[loop_order][0];
    dm = ord_tab[loop_order][1];
    dout = ord_tab[loop_order][2];
    pa.delete(); pb.delete(); pp.delete();
    for (int o = 0; o < len[dout]; o++)
      for (int m = 0; m < len[dm]; m++)
        for (int i = 0; i < len[di]; i++) begin
          pt[dout] = vals[dout][o];
          pt[dm] = vals[dm][m];
          pt[di] = vals[di][i];
          pa.push_back(pt[0]); pb.push_back(pt[1]); pp.push_back(pt[2]);
        end
  endtask

  // mode: 0 normal, 1 abort in pulse cycle 2, 2 abort with passing verify, 3 reset in verify
  task automatic applyStimulus(input int mode, input int pass_at);
    int exp_n, lim, exp_pulses, npulse, run, exp_len, setup_run, lat, total;
    bit fin, got_done, req_drv, rst_drv, prev_pe, exp_success;
    buildModel();
    exp_n = pa.size();
    lim = (max_attempts == 0 || int'(max_attempts) > exp_n) ? exp_n : int'(max_attempts);
    exp_pulses = (pass_at > 0 && pass_at < lim) ? pass_at : lim;
    exp_success = (pass_at > 0 && pass_at <= lim);
    npulse = 0; run = 0; exp_len = 1; setup_run = 0; lat = -1; total = 0;
    fin = 0; got_done = 0; req_drv = 0; rst_drv = 0; prev_pe = 0;

    @(negedge mclk);
    checkOutput("busy_idle", busy, 0);
    start = 1'b1;
    @(negedge mclk);
    start = 1'b0;
    checkOutput("busy_rise", busy, 1);

    for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
      if (cyc > 0) @(negedge mclk);
      abort = 1'b0; vfy_done = 1'b0; vfy_pass = 1'b0;
      if (rst_drv) begin
        checkReset("mid_reset");
        rst_n = 1'b1;
        fin = 1;
      end else if (done) begin
        got_done = 1; fin = 1;
        if (mode == 1 || mode == 2) begin
          checkOutput("abort_flag", aborted, 1);
          checkOutput("abort_success", success, 0);
          checkOutput("abort_pulse_off", pulse_en, 0);
          checkOutput("abort_attempts", attempts, 1);
        end else begin
          checkOutput("n_pulses", npulse, exp_pulses);
          checkOutput("final_attempts", attempts, exp_pulses);
          checkOutput("success", success, exp_success);
          checkOutput("aborted", aborted, 0);
        end
`ifdef PULSE_SWEEP_STATS_EN
        checkOutput("pulse_cycles", pulse_cycles, total);
`endif
      end else begin
        if (req_drv) begin
          checkOutput("vfy_req_drop", vfy_req, 0);
          req_drv = 0;
        end
        if (pulse_en) begin
          if (!prev_pe) begin
            npulse++;
            checkOutput("setup_len", setup_run, SETUP_CYC);
            checkOutput("attempts_inc", attempts, npulse);
            if (npulse <= exp_n) begin
              checkOutput("pt_a", lvl_a, pa[npulse-1]);
              checkOutput("pt_b", lvl_b, pb[npulse-1]);
              checkOutput("pt_pw", cur_pw, pp[npulse-1]);
              exp_len = (pp[npulse-1] == 0) ? 1 : pp[npulse-1];
            end else begin
              checkOutput("extra_pulse", npulse, exp_n);
            end
            setup_run = 0; run = 0;
          end
          run++; total++;
          if (mode == 1 && npulse == 1 && run == 2) abort = 1'b1;
        end else begin
          if (prev_pe) checkOutput("pulse_len", run, exp_len);
          if (busy && !vfy_req) setup_run++;
        end
        prev_pe = pulse_en;
        if (vfy_req) begin
          if (lat < 0) lat = $urandom_range(0, 2);
          if (lat == 0) begin
            vfy_done = 1'b1;
            vfy_pass = (npulse == pass_at);
            req_drv = 1; lat = -1;
            if (mode == 2) begin vfy_pass = 1'b1; abort = 1'b1; end
            if (mode == 3) begin rst_n = 1'b0; rst_drv = 1; end
          end else begin
            lat--;
          end
        end
      end
    end
    if (!fin) checkOutput("timeout", 0, 1);
    abort = 1'b0; vfy_done = 1'b0; vfy_pass = 1'b0; rst_n = 1'b1;
    if (got_done) begin
      @(negedge mclk);
      checkOutput("done_1cyc", {done, busy}, 0);
    end
  endtask

  initial begin
    $display("[TB] pulse_sweep_seq bench start");
    rst_n = 1'b0;
    repeat (3) @(negedge mclk);
    checkReset("reset");
    rst_n = 1'b1;

    loadConfig(0, 4, 2, 10, 11, 1, 3, 3, 1, 0, 0);       applyStimulus(0, 0);
    loadConfig(7, 7, 1, 7, 7, 1, 1, 8, 2, 3, 0);         applyStimulus(0, 3);
    loadConfig(0, 2, 1, 0, 2, 1, 1, 3, 1, 0, 2);         applyStimulus(0, 0);
    loadConfig(250, 255, 10, 5, 3, 1, 4, 9, 0, 0, 0);    applyStimulus(0, 0);
    loadConfig(0, 0, 1, 0, 0, 1, 8, 8, 1, 0, 0);         applyStimulus(1, 0);
    loadConfig(1, 5, 2, 0, 0, 1, 2, 2, 1, 1, 0);         applyStimulus(2, 0);
    loadConfig(0, 2, 1, 0, 2, 1, 1, 3, 1, 2, 0);         applyStimulus(3, 0);
    applyStimulus(0, 0);

    repeat (12) begin
      loadConfig($urandom_range(0, 255), $urandom_range(0, 255),
                 ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(60, 120),
                 $urandom_range(0, 255), $urandom_range(0, 255),
                 ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(60, 120),
                 $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 2),
                 $urandom_range(0, 7), $urandom_range(0, 12));
      applyStimulus(0, $urandom_range(0, 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pulse_sweep_seq.md
Name: pulse_sweep_seq

Overview:
- Parametrised write-pulse sweep sequencer for RRAM write-verify.
- Generalises the fixed set/reset loop of the top-level FSM into one reusable engine.
- Steps two DAC levels (A, B) and a pulse width through nested loops with programmable loop order; width and attempt limits are set by parameters.
- After each pulse, requests a verify from the read path; stops on pass, attempt limit, sweep exhaustion or abort. Sits between the FSM controller and the WL/BL/SL DAC config outputs.

Parameters:
- LVL_W, 8, width of DAC level A/B fields.
- PW_W, 8, width of pulse-width field, in mclk cycles.
- ATT_W, 8, width of attempt counter and max_attempts.
- SETUP_CYC, 2, settle cycles before each pulse (>=1).

Ports:
- mclk in 1: clock.
- rst_n in 1: synchronous active-low reset.
- start in 1: begin a sweep; sampled only in IDLE.
- abort in 1: terminate the sweep from any non-IDLE state.
- lvl_a_start/lvl_a_stop/lvl_a_step in LVL_W each: level A range.
- lvl_b_start/lvl_b_stop/lvl_b_step in LVL_W each: level B range.
- pw_start/pw_stop/pw_step in PW_W each: pulse-width range.
- loop_order in 3: loop nesting encoding.
- max_attempts in ATT_W: attempt limit; 0 means unlimited.
- vfy_done in 1: verify result valid.
- vfy_pass in 1: verify result, qualified by vfy_done.
- lvl_a out LVL_W: current level A.
- lvl_b out LVL_W: current level B.
- cur_pw out PW_W: current pulse width.
- pulse_en out 1: write pulse active.
- vfy_req out 1: verify request.
- busy out 1: high when not IDLE.
- done out 1: one-cycle completion strobe.
- success out 1: verify passed; valid with done, held until next start.
- aborted out 1: sweep was aborted; valid with done, held until next start.
- attempts out ATT_W: pulses issued in the current or last sweep.

Behaviour:
- Reset (rst_n low at posedge): state IDLE; all outputs 0; counters cleared. Reset mid-pulse drops pulse_en on the next edge.
- States: IDLE, SETUP, PULSE, VERIFY, DONE.
- IDLE: on start, load lvl_a=lvl_a_start, lvl_b=lvl_b_start, cur_pw=pw_start; clear attempts, success, aborted; go to SETUP. busy rises 1 cycle after start.
- SETUP: lasts exactly SETUP_CYC cycles; levels stable; then go to PULSE.
- PULSE: pulse_en high for exactly max(cur_pw,1) cycles; attempts increments on the PULSE entry edge, saturating at all-ones; then go to VERIFY.
- VERIFY: vfy_req high until vfy_done is sampled high; vfy_req is low in the cycle after vfy_done.
  - vfy_pass=1: go to DONE with success=1.
  - Fail, and (max_attempts!=0 and attempts==max_attempts) or the sweep is exhausted: go to DONE with success=0.
  - Fail otherwise: advance the sweep point and go to SETUP.
- DONE: done=1 for one cycle, then go to IDLE. start in DONE is ignored.
- abort: in SETUP, PULSE or VERIFY, go to DONE next cycle with aborted=1, success=0, pulse_en=0.
  - abort in DONE or IDLE: no effect.
  - abort and vfy_done in the same cycle: abort wins.
- Dimension advance, per dimension (start, stop, step):
  - next = cur + step, computed at width+1.
  - If step==0, or the carry bit is set, or next>stop: wrap to start and carry into the next-outer dimension.
  - If start>stop, the dimension holds the single value start.
- Sweep is exhausted when the outermost dimension carries.
- loop_order, listed inner->mid->outer:
  - 0: pw,b,a
  - 1: pw,a,b
  - 2: b,pw,a
  - 3: b,a,pw
  - 4: a,pw,b
  - 5: a,b,pw
  - 6 and 7 behave as 0.
- Range inputs and loop_order are sampled every cycle; they are only required to stay stable while busy=1.

Optional Feature:
- Macro: PULSE_SWEEP_STATS_EN.
- With the macro: adds output pulse_cycles (24 bits), the total pulse_en-high cycles in the current sweep. It clears on start and saturates at all-ones.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package pulse_sweep_pkg holds:
  - the state enum (IDLE, SETUP, PULSE, VERIFY, DONE);
  - the loop_order localparams;
  - the function mapping loop_order to inner/mid/outer dimension indices.
- Sub-module sweep_dim (parameter W): one dimension register with load/advance/wrap logic; outputs value and carry. It is instantiated three times, and the carry chain is wired per loop_order.

Test Plan:
- Order and exhaustion:
  - Stimulus: lvl_a 0..4 step 2, lvl_b 10..11 step 1, pw 3..3, loop_order=0, max_attempts=0, verify always fails.
  - Response: 6 pulses in order (a,b) = (0,10),(0,11),(2,10),(2,11),(4,10),(4,11); each pulse_en run is 3 cycles; done with success=0, attempts=6.
- Pass on third attempt:
  - Stimulus: pw 1..8 step 2, loop_order=3, vfy_pass on third verify.
  - Response: cur_pw sequence 1,3,5; success=1, attempts=3.
- Attempt limit and timing:
  - Stimulus: max_attempts=2 on a 27-point sweep, always fail.
  - Response: done after 2 pulses; SETUP measured at SETUP_CYC=2 cycles before each pulse.
- Edge ranges:
  - Stimulus: lvl_a start=250, stop=255, step=10 (overflow); lvl_b start=5, stop=3; pw step=0.
  - Response: each dimension wraps immediately; exactly 1 pulse; done with success=0 on fail.
- Abort mid-pulse:
  - Stimulus: abort in cycle 2 of an 8-cycle pulse.
  - Response: pulse_en low next cycle; done=1 with aborted=1.
  - Stimulus: abort coincident with vfy_done&vfy_pass.
  - Response: aborted=1, success=0.
- Reset mid-operation:
  - Stimulus: rst_n low during VERIFY.
  - Response: all outputs 0 after the edge; a new start runs a clean sweep with attempts counted from 1.
